// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID reader: FSM encodings, word addresses
// and the default expected ID / build-timestamp values.
package sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_ID = 3'd1,
        ST_LAT_ID = 3'd2,
        ST_REQ_TS = 3'd3,
        ST_LAT_TS = 3'd4,
        ST_FIN    = 3'd5
    } sysid_state_e;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_REQ  = 2'd1,
        RD_LAT  = 2'd2
    } rd_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_EXP_ID_DEF = 32'h0000_0000;
    localparam logic [31:0] SYSID_EXP_TS_DEF = 32'd1459559916;

    localparam int SYSID_LAT_W = 3;

endpackage

// File: rtl/avm_single_read.sv
// One Avalon-MM read transaction: request held until accepted, fixed read
// latency, and abort after TIMEOUT_CYCLES stalled request cycles.
module avm_single_read
    import sysid_pkg::*;
#(
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        go,
    input  logic        addr,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        rd_accept,
    output logic        rd_done,
    output logic        rd_timeout,
    output logic [31:0] rd_data
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [SYSID_LAT_W-1:0] LAT_N   = SYSID_LAT_W'(READ_LATENCY);
    localparam logic [SYSID_LAT_W-1:0] LAT_ONE = SYSID_LAT_W'(1);

    rd_state_e              state_q, state_d;
    logic                   addr_q, addr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYSID_LAT_W-1:0] lat_q, lat_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        rd_accept  = 1'b0;
        rd_done    = 1'b0;
        rd_timeout = 1'b0;

        case (state_q)
            RD_IDLE: begin
                if (go) begin
                    state_d = RD_REQ;
                    addr_d  = addr;
                    cnt_d   = '0;
                end
            end
            RD_REQ: begin
                if (!avm_waitrequest) begin
                    addr_d = SYSID_ADDR_ID;
                    if (READ_LATENCY == 0) begin
                        rd_done = 1'b1;
                        state_d = RD_IDLE;
                    end else begin
                        rd_accept = 1'b1;
                        lat_d     = LAT_ONE;
                        state_d   = RD_LAT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_MAX) begin
                        rd_timeout = 1'b1;
                        addr_d     = SYSID_ADDR_ID;
                        state_d    = RD_IDLE;
                    end
                end
            end
            RD_LAT: begin
                // lat_q counts cycles since the accept cycle; data is taken at exactly N.
                if (lat_q == LAT_N) begin
                    rd_done = 1'b1;
                    state_d = RD_IDLE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments; the async reset also drops avm_read at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RD_IDLE;
            addr_q  <= SYSID_ADDR_ID;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

    assign avm_read    = (state_q == RD_REQ);
    assign avm_address = addr_q;
    assign rd_data     = avm_readdata;

endmodule

// File: rtl/sysid_reader.sv
// Boot-time image check: reads the system ID and build timestamp from the
// system-ID slave and reports match / mismatch / timeout.
module sysid_reader
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXP_ID         = SYSID_EXP_ID_DEF,
    parameter logic [31:0] EXP_TIMESTAMP  = SYSID_EXP_TS_DEF,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    sysid_state_e state_q, state_d;
    logic         go_q, go_d;
    logic         id_ok_q, id_ok_d;
    logic         ts_ok_q, ts_ok_d;
    logic         timeout_q, timeout_d;
    logic [31:0]  id_value_q, id_value_d;
    logic [31:0]  ts_value_q, ts_value_d;

    logic        rd_addr;
    logic        rd_accept;
    logic        rd_done;
    logic        rd_timeout;
    logic [31:0] rd_data;

    assign rd_addr = (state_q == ST_REQ_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;

    avm_single_read #(
        .READ_LATENCY   (READ_LATENCY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_read (
        .clock           (clock),
        .reset_n         (reset_n),
        .go              (go_q),
        .addr            (rd_addr),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .rd_accept       (rd_accept),
        .rd_done         (rd_done),
        .rd_timeout      (rd_timeout),
        .rd_data         (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_REQ_ID;
                    id_ok_d    = 1'b0;
                    ts_ok_d    = 1'b0;
                    timeout_d  = 1'b0;
                    id_value_d = '0;
                    ts_value_d = '0;
                end
            end
            ST_REQ_ID, ST_LAT_ID: begin
                if (rd_timeout) begin
                    timeout_d = 1'b1;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    state_d   = ST_FIN;
                end else if (rd_done) begin
                    id_value_d = rd_data;
                    id_ok_d    = (rd_data == EXP_ID);
                    state_d    = ST_REQ_TS;
                end else if (rd_accept) begin
                    state_d = ST_LAT_ID;
                end
            end
            ST_REQ_TS, ST_LAT_TS: begin
                if (rd_timeout) begin
                    timeout_d = 1'b1;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    state_d   = ST_FIN;
                end else if (rd_done) begin
                    ts_value_d = rd_data;
                    ts_ok_d    = (rd_data == EXP_TIMESTAMP);
                    state_d    = ST_FIN;
                end else if (rd_accept) begin
                    state_d = ST_LAT_TS;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // The reader is kicked once on entry to each request state; its own
        // idle cycle gives the mandatory gap between the two reads.
        go_d = (state_d != state_q) &&
               ((state_d == ST_REQ_ID) || (state_d == ST_REQ_TS));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            go_q       <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            state_q    <= state_d;
            go_q       <= go_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

    assign busy     = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done     = (state_q == ST_FIN);
    assign id_ok    = id_ok_q;
    assign ts_ok    = ts_ok_q;
    assign timeout  = timeout_q;
    assign id_value = id_value_q;
    assign ts_value = ts_value_q;

endmodule

// File: tb/tb_sysid_reader.sv
// Directed bench for sysid_reader: behavioural Avalon slaves, a result
// scoreboard and protocol monitors on a latency-0 and a latency-2 instance.
module tb_sysid_reader;

    localparam int          TO      = 8;
    localparam logic [31:0] EXP_TS  = 32'd1459559916;
    localparam logic [31:0] BAD_TS  = 32'h5700_0000;

    typedef struct {
        logic [31:0] id_v;
        logic [31:0] ts_v;
        logic        id_ok;
        logic        ts_ok;
        logic        to;
        int          done_at;
        int          start_at;
    } exp_t;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        id_ok;
        logic        ts_ok;
        logic        to;
        logic        rd;
        logic        addr;
        logic [31:0] idv;
        logic [31:0] tsv;
    } outs_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // latency-0 instance
    logic        start0 = 1'b0;
    logic        avm_address0, avm_read0, busy0, done0, id_ok0, ts_ok0, timeout0;
    logic        wr0 = 1'b0;
    logic [31:0] rdata0 = 32'hDEAD_BEEF;
    logic [31:0] id_value0, ts_value0;

    // latency-2 instance
    logic        start2 = 1'b0;
    logic        avm_address2, avm_read2, busy2, done2, id_ok2, ts_ok2, timeout2;
    logic        wr2;
    logic [31:0] rdata2 = 32'hDEAD_BEEF;
    logic [31:0] id_value2, ts_value2;
    assign wr2 = 1'b0;

    sysid_reader #(.READ_LATENCY(0), .TIMEOUT_CYCLES(TO)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .start(start0),
        .avm_address(avm_address0), .avm_read(avm_read0),
        .avm_waitrequest(wr0), .avm_readdata(rdata0),
        .busy(busy0), .done(done0), .id_ok(id_ok0), .ts_ok(ts_ok0),
        .timeout(timeout0), .id_value(id_value0), .ts_value(ts_value0)
    );

    sysid_reader #(.READ_LATENCY(2), .TIMEOUT_CYCLES(TO)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .start(start2),
        .avm_address(avm_address2), .avm_read(avm_read2),
        .avm_waitrequest(wr2), .avm_readdata(rdata2),
        .busy(busy2), .done(done2), .id_ok(id_ok2), .ts_ok(ts_ok2),
        .timeout(timeout2), .id_value(id_value2), .ts_value(ts_value2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];

    // slave 0 knobs and monitor counters
    int          wait_n    = 0;
    bit          stall_all = 1'b0;
    bit          stall_ts  = 1'b0;
    logic [31:0] id_word   = 32'h0;
    logic [31:0] ts_word   = EXP_TS;
    int          st_cnt0   = 0;
    int          rd_hi0    = 0;
    int          addr1_0   = 0;
    int          viol0     = 0;
    int          done_cnt0 = 0;
    bit          acc_prev0 = 1'b0;
    bit          rd_prev0  = 1'b0;
    logic        addr_prev0 = 1'b0;

    // slave 2 state
    int   acc_cyc2  = -100;
    logic acc_addr2 = 1'b0;
    int   viol2     = 0;

    always @(negedge clock) begin
        if (acc_prev0 && avm_read0) viol0++;
        if (rd_prev0 && !acc_prev0 && avm_read0 && (avm_address0 !== addr_prev0)) viol0++;
        if (avm_read0) rd_hi0++;
        if (avm_read0 && avm_address0) addr1_0++;
        if (done0) done_cnt0++;
        if (avm_read0) begin
            if (stall_all || (stall_ts && avm_address0) || (st_cnt0 < wait_n)) begin
                wr0 = 1'b1;
                st_cnt0++;
                rdata0 = 32'hBAD0_0000 | 32'(cyc);
            end else begin
                wr0 = 1'b0;
                rdata0 = avm_address0 ? ts_word : id_word;
            end
        end else begin
            wr0 = 1'b0;
            st_cnt0 = 0;
            rdata0 = 32'hDEAD_BEEF;
        end
        acc_prev0  = avm_read0 && !wr0;
        rd_prev0   = avm_read0;
        addr_prev0 = avm_address0;
    end

    // Latency-2 slave: never stalls; data valid only two cycles after accept.
    always @(negedge clock) begin
        if (avm_read2 && (cyc > acc_cyc2) && (cyc <= acc_cyc2 + 2)) viol2++;
        if (cyc == acc_cyc2 + 2) rdata2 = acc_addr2 ? ts_word : id_word;
        else                     rdata2 = 32'hC0DE_0000 | 32'(cyc);
        if (avm_read2) begin
            acc_cyc2  = cyc;
            acc_addr2 = avm_address2;
        end
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic outs_t get_outs(input int d);
        outs_t o;
        if (d == 0) o = '{busy0, done0, id_ok0, ts_ok0, timeout0, avm_read0, avm_address0, id_value0, ts_value0};
        else        o = '{busy2, done2, id_ok2, ts_ok2, timeout2, avm_read2, avm_address2, id_value2, ts_value2};
        return o;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] idv, input logic [31:0] tsv,
                                    input logic iok, input logic tok, input logic to, input int d_at);
        exp_t e;
        e.id_v = idv; e.ts_v = tsv; e.id_ok = iok; e.ts_ok = tok; e.to = to;
        e.done_at = d_at; e.start_at = 0;
        return e;
    endfunction

    task automatic clr_mon();
        #1;
        rd_hi0 = 0; addr1_0 = 0; viol0 = 0; done_cnt0 = 0; viol2 = 0;
    endtask

    // Pulse start for one cycle; the expected outcome goes on the scoreboard.
    task automatic kick(input int d, input string tag, input exp_t e);
        outs_t o;
        e.start_at = cyc;
        sb.push_back(e);
        if (d == 0) start0 = 1'b1; else start2 = 1'b1;
        @(negedge clock);
        start0 = 1'b0; start2 = 1'b0;
        o = get_outs(d);
        check({tag, ".busy_after_start"}, o.busy, 1'b1);
    endtask

    task automatic finish_seq(input int d, input string tag, input bit poke_fin);
        bit    seen = 1'b0;
        outs_t o;
        exp_t  e;
        for (int n = 0; n < 200 && !seen; n++) begin
            o = get_outs(d);
            if (o.done) seen = 1'b1;
            else @(negedge clock);
        end
        check({tag, ".done_seen"}, seen, 1'b1);
        e = sb.pop_front();
        if (seen) begin
            check({tag, ".done_cycle"}, cyc - e.start_at, e.done_at);
            check({tag, ".busy_at_done"}, o.busy, 1'b0);
            check({tag, ".id_ok"},    o.id_ok, e.id_ok);
            check({tag, ".ts_ok"},    o.ts_ok, e.ts_ok);
            check({tag, ".timeout"},  o.to,    e.to);
            check({tag, ".id_value"}, o.idv,   e.id_v);
            check({tag, ".ts_value"}, o.tsv,   e.ts_v);
            if (poke_fin) begin
                start0 = 1'b1;
                @(negedge clock);
                start0 = 1'b0;
                o = get_outs(0);
                check({tag, ".fin_start_ignored"}, {o.busy, o.done, o.rd}, 3'b000);
                check({tag, ".results_held"}, {o.id_ok, o.ts_ok, o.to}, {e.id_ok, e.ts_ok, e.to});
            end
        end
    endtask

    initial begin
        bit seen_ts;
        repeat (3) @(negedge clock);
        check("reset.dut0_outputs", get_outs(0), '0);
        check("reset.dut2_outputs", get_outs(2), '0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // zero-wait pass; start during FIN must be ignored
        clr_mon();
        kick(0, "pass", mk_exp(32'h0, EXP_TS, 1'b1, 1'b1, 1'b0, 5));
        finish_seq(0, "pass", 1'b1);
        #1;
        check("pass.read_cycles", rd_hi0, 2);
        check("pass.addr1_cycles", addr1_0, 1);
        check("pass.protocol", viol0, 0);
        @(negedge clock);

        // timestamp mismatch
        ts_word = BAD_TS;
        clr_mon();
        kick(0, "ts_bad", mk_exp(32'h0, BAD_TS, 1'b1, 1'b0, 1'b0, 5));
        finish_seq(0, "ts_bad", 1'b0);
        repeat (2) @(negedge clock);

        // three stall cycles per read
        ts_word = EXP_TS;
        wait_n  = 3;
        clr_mon();
        kick(0, "wait3", mk_exp(32'h0, EXP_TS, 1'b1, 1'b1, 1'b0, 11));
        finish_seq(0, "wait3", 1'b0);
        #1;
        check("wait3.read_cycles", rd_hi0, 8);
        check("wait3.addr1_cycles", addr1_0, 4);
        check("wait3.protocol", viol0, 0);
        @(negedge clock);

        // waitrequest stuck high: abort on the ID read
        wait_n    = 0;
        stall_all = 1'b1;
        clr_mon();
        kick(0, "timeout", mk_exp(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 10));
        finish_seq(0, "timeout", 1'b0);
        #1;
        check("timeout.read_cycles", rd_hi0, TO);
        check("timeout.addr1_cycles", addr1_0, 0);
        @(negedge clock);
        stall_all = 1'b0;
        repeat (2) @(negedge clock);

        // latency-2 slave with garbage outside the data cycle
        clr_mon();
        kick(2, "lat2", mk_exp(32'h0, EXP_TS, 1'b1, 1'b1, 1'b0, 9));
        finish_seq(2, "lat2", 1'b0);
        #1;
        check("lat2.read_low_in_latency", viol2, 0);
        @(negedge clock);

        // reset in the middle of the timestamp request
        stall_ts = 1'b1;
        start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        seen_ts = 1'b0;
        for (int n = 0; n < 50 && !seen_ts; n++) begin
            if (avm_read0 && avm_address0) seen_ts = 1'b1;
            else @(negedge clock);
        end
        check("rst_mid.reached_req_ts", seen_ts, 1'b1);
        #2 reset_n = 1'b0;
        #1 check("rst_mid.read_async_low", avm_read0, 1'b0);
        @(negedge clock);
        check("rst_mid.dut0_outputs", get_outs(0), '0);
        check("rst_mid.dut2_outputs", get_outs(2), '0);
        stall_ts = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // fresh sequence after reset, with a second start while busy
        clr_mon();
        kick(0, "post_rst", mk_exp(32'h0, EXP_TS, 1'b1, 1'b1, 1'b0, 5));
        start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        finish_seq(0, "post_rst", 1'b0);
        repeat (10) @(negedge clock);
        #1;
        check("post_rst.single_done", done_cnt0, 1);
        check("post_rst.read_cycles", rd_hi0, 2);
        check("post_rst.protocol", viol0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
